// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its queue.
package instruction_fetch_sequencer_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } q_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction
endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, program memory, execute redirect and decode.
interface instruction_fetch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  import instruction_fetch_sequencer_pkg::*;

  logic                  fetch_enable;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_instr;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  // Decode stream: an entry transfers on a rising edge where out_valid and out_ready
  // are both high; out_valid never depends on out_ready, and out_* hold until accepted.
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_pc_plus4;
  logic                  misalign_err;
  q_state_e              q_state;

  modport master (
    input  fetch_enable, imem_instr, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, misalign_err, q_state
  );

  modport slave (
    output fetch_enable, imem_instr, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, misalign_err, q_state
  );
endinterface

// File: rtl/instruction_fetch_sequencer_fetch_queue.sv
// Two-entry instruction queue held as head/tail registers so decode sees registered outputs.
module instruction_fetch_sequencer_fetch_queue
  import instruction_fetch_sequencer_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     flush_i,
  input  q_entry_t push_entry_i,
  output q_entry_t head_o,
  output q_state_e state_o
);
  q_entry_t head_q;
  q_entry_t tail_q;
  q_state_e state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= Q_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush_i) begin
      state_q <= Q_EMPTY;
    end else begin
      case (state_q)
        Q_EMPTY: begin
          if (push_i) begin
            head_q  <= push_entry_i;
            state_q <= Q_ONE;
          end
        end
        Q_ONE: begin
          case ({push_i, pop_i})
            2'b10: begin
              tail_q  <= push_entry_i;
              state_q <= Q_FULL;
            end
            2'b01:   state_q <= Q_EMPTY;
            2'b11:   head_q  <= push_entry_i;
            default: state_q <= Q_ONE;
          endcase
        end
        Q_FULL: begin
          // A push here is only possible alongside a pop, refilling the freed slot.
          if (pop_i) begin
            head_q <= tail_q;
            if (push_i) tail_q  <= push_entry_i;
            else        state_q <= Q_ONE;
          end
        end
        default: state_q <= Q_EMPTY;
      endcase
    end
  end

  assign head_o  = head_q;
  assign state_o = state_q;
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Owns the fetch PC, addresses the asynchronous ROM and feeds fetched words into the queue.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  instruction_fetch_sequencer_if.master bus
);
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  misalign_q, misalign_d;
  logic                  push, pop;
  q_state_e              q_state;
  q_entry_t              head;
  q_entry_t              push_entry;

  assign pop  = (q_state != Q_EMPTY) & bus.out_ready;
  assign push = bus.fetch_enable & ~bus.redirect_valid & ((q_state != Q_FULL) | pop);

  assign push_entry.instr = bus.imem_instr;
  assign push_entry.pc    = fetch_pc_q;

  // Redirect outranks fetch; the pop of that cycle still completes inside the queue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    misalign_d = misalign_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_word(bus.redirect_pc);
      if (bus.redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  instruction_fetch_sequencer_fetch_queue u_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (bus.redirect_valid),
    .push_entry_i (push_entry),
    .head_o       (head),
    .state_o      (q_state)
  );

  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = (q_state != Q_EMPTY);
  assign bus.out_instr    = head.instr;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus4 = head.pc + INSTR_BYTES;
  assign bus.misalign_err = misalign_q;
  assign bus.q_state      = q_state;
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for the fetch sequencer driven against a small ROM model.
module tb_instruction_fetch_sequencer;
  import instruction_fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp;

  instruction_fetch_sequencer_if bus ();

  instruction_fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr)
      32'h0: return 32'h2008_0005;
      32'h4: return 32'h2009_0007;
      32'h8: return 32'h0109_5020;
      default: return addr ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign bus.imem_instr = rom_word(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    exp_q.delete();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", bus.out_instr); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
    n_cmp++; if (bus.out_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4 got %h want 4", bus.out_pc_plus4); end
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", bus.misalign_err); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_imem_addr got %h want 0", bus.imem_addr); end
    n_cmp++; if (bus.q_state !== Q_EMPTY) begin n_err++; $display("FAIL reset_qstate got %0d want 0", bus.q_state); end
  endtask

  task automatic test_stream();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back({rom_word(32'(i * 4)), 32'(i * 4)});
    step();
    n_cmp++; if (bus.out_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL stream_first_plus4 got %h want 4", bus.out_pc_plus4); end
    for (int c = 0; c < 4; c++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[63:32] || bus.out_pc !== exp[31:0]) begin
        n_err++;
        $display("FAIL stream[%0d] got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", c, bus.out_valid, bus.out_instr, bus.out_pc, exp[63:32], exp[31:0]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (5) step();
    n_cmp++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_imem_addr got %h want 8", bus.imem_addr); end
    n_cmp++; if (bus.q_state !== Q_FULL) begin n_err++; $display("FAIL bp_qstate got %0d want 2", bus.q_state); end
    for (int i = 0; i < 4; i++) exp_q.push_back({rom_word(32'(i * 4)), 32'(i * 4)});
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[63:32] || bus.out_pc !== exp[31:0]) begin
        n_err++;
        $display("FAIL bp_drain[%0d] got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", c, bus.out_valid, bus.out_instr, bus.out_pc, exp[63:32], exp[31:0]);
      end
      step();
    end
  endtask

  task automatic test_redirect_full();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (3) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    exp_q.push_back({rom_word(32'h40), 32'h40});
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_imem_addr got %h want 40", bus.imem_addr); end
    step();
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[63:32] || bus.out_pc !== exp[31:0]) begin
      n_err++;
      $display("FAIL redir_target got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", bus.out_valid, bus.out_instr, bus.out_pc, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_misalign();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    repeat (2) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h42;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_set got %b want 1", bus.misalign_err); end
    n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL misalign_addr got %h want 40", bus.imem_addr); end
    step();
    n_cmp++; if (bus.out_pc !== 32'h40 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL misalign_fetch got v=%b pc=%h want v=1 pc=40", bus.out_valid, bus.out_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    step();
    n_cmp++; if (bus.misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_sticky got %b want 1", bus.misalign_err); end
    do_reset();
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_clear got %b want 0", bus.misalign_err); end
  endtask

  task automatic test_back_to_back();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    repeat (2) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    step();
    bus.redirect_pc = 32'hC0;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'hC0) begin n_err++; $display("FAIL b2b_flush got v=%b addr=%h want v=0 addr=c0", bus.out_valid, bus.imem_addr); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hC0 || bus.out_instr !== rom_word(32'hC0)) begin n_err++; $display("FAIL b2b_target got v=%b pc=%h instr=%h want v=1 pc=c0 instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, rom_word(32'hC0)); end
  endtask

  task automatic test_wrap();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back({rom_word(32'hFFFF_FFFC), 32'hFFFF_FFFC});
    exp_q.push_back({32'h2008_0005, 32'h0});
    step();
    bus.redirect_valid = 1'b0;
    step();
    for (int c = 0; c < 2; c++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[63:32] || bus.out_pc !== exp[31:0]) begin
        n_err++;
        $display("FAIL wrap[%0d] got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", c, bus.out_valid, bus.out_instr, bus.out_pc, exp[63:32], exp[31:0]);
      end
      n_cmp++; if (bus.out_pc_plus4 !== exp[31:0] + 32'd4) begin n_err++; $display("FAIL wrap_plus4[%0d] got %h want %h", c, bus.out_pc_plus4, exp[31:0] + 32'd4); end
      step();
    end
  endtask

  task automatic test_fetch_disable();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (3) step();
    bus.fetch_enable = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.push_back({rom_word(32'h0), 32'h0});
    exp_q.push_back({rom_word(32'h4), 32'h4});
    for (int c = 0; c < 2; c++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[63:32] || bus.out_pc !== exp[31:0]) begin
        n_err++;
        $display("FAIL disable_drain[%0d] got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", c, bus.out_valid, bus.out_instr, bus.out_pc, exp[63:32], exp[31:0]);
      end
      step();
    end
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL disable_hold[%0d] got v=%b addr=%h want v=0 addr=8", c, bus.out_valid, bus.imem_addr); end
      step();
    end
    bus.fetch_enable = 1'b1;
  endtask

  task automatic test_reset_midstream();
    bus.fetch_enable = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.out_pc !== 32'h0) begin n_err++; $display("FAIL midreset got v=%b addr=%h pc=%h want v=0 addr=0 pc=0", bus.out_valid, bus.imem_addr, bus.out_pc); end
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h2008_0005) begin n_err++; $display("FAIL midreset_restart got v=%b pc=%h instr=%h want v=1 pc=0 instr=20080005", bus.out_valid, bus.out_pc, bus.out_instr); end
  endtask

  initial begin
    bus.fetch_enable = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_fetch_disable();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1);
  end
endmodule

// File: doc/instruction_fetch_sequencer.md
Name: instruction_fetch_sequencer

Overview:
Sequences the asynchronous-read program memory ROM for the MIPS core: owns the fetch PC, drives the ROM byte address, and captures each returned word into a 2-entry instruction queue. Presents a valid/ready stream of {instruction, PC} to decode. Branch/jump redirects from execute flush the queue and restart fetch at the target. Sits between the program memory and the decode stage.

Parameters:
DATA_WIDTH, 32, width of address, PC and instruction
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (must be word aligned)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_enable  input  1  1 = fetching allowed; 0 = hold fetch PC, queue still drains
imem_addr  output  DATA_WIDTH  byte address to program memory (combinational from fetch_pc)
imem_instr  input  DATA_WIDTH  word returned by program memory, same cycle
redirect_valid  input  1  execute requests a PC change this cycle
redirect_pc  input  DATA_WIDTH  redirect target byte address
out_valid  output  1  head queue entry valid
out_ready  input  1  decode accepts head entry
out_instr  output  DATA_WIDTH  head instruction
out_pc  output  DATA_WIDTH  PC of head instruction
out_pc_plus4  output  DATA_WIDTH  out_pc + 4 (mod 2^32)
misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- One clock, clk; reset asynchronous active-high. On reset: fetch_pc=RESET_PC, queue count=0, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=4, misalign_err=0. All take effect immediately, without a clock edge.
- imem_addr = fetch_pc, combinationally; ROM read is combinational, so imem_instr is valid in the same cycle.
- Queue state = count in {EMPTY(0), ONE(1), FULL(2)}. out_* always reflect the head entry from registered storage. out_valid = (count != 0).
- pop = out_valid & out_ready.
- push = fetch_enable & ~redirect_valid & (count<2 | pop). Push writes {imem_instr, fetch_pc} to the tail and sets fetch_pc <= fetch_pc + 4.
- Latency: a word fetched in cycle N appears at out_* in cycle N+1. With out_ready held high, throughput is 1 instruction/cycle.
- Transitions: EMPTY -push-> ONE. ONE -push&~pop-> FULL. ONE -pop&~push-> EMPTY. ONE -push&pop-> ONE. FULL -pop-> ONE, or FULL when refilled the same cycle. In FULL without pop, no push occurs and fetch_pc holds.
- Redirect (highest priority): the pop in that cycle still completes, since decode sampled a valid head. Next state: count=0, fetch_pc <= {redirect_pc[31:2],2'b00}, no push. out_valid=0 in the following cycle, and the target instruction is visible one cycle after that.
- A redirect with redirect_pc[1:0]!=0 sets misalign_err=1. It stays set until reset. Fetch continues at the aligned address.
- Back-to-back redirects: each one overrides; the last target wins.
- fetch_enable=0: no push, fetch_pc holds, existing entries remain poppable. Redirects are still honoured.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. out_pc_plus4 wraps the same way.
- Reset asserted mid-operation discards queue contents, with no partial outputs. Fetch restarts at RESET_PC on the first edge after reset deasserts.

Decomposition:
- Shared package: RESET_PC default, INSTR_BYTES=4, WORD_ALIGN_MASK=32'hFFFF_FFFC, queue entry type {instr[31:0], pc[31:0]}, count-state encoding (EMPTY/ONE/FULL).
- One sub-module: fetch_queue, a 2-entry FIFO with push/pop/flush, count, head outputs, and asynchronous active-high reset. The sequencer holds fetch_pc, push/pop logic and the error flag.

Test Plan:
- Reset release, fetch_enable=1, out_ready=1, ROM[0..2]=20080005,20090007,01095020 -> first cycle after release: out_valid=1, out_instr=20080005, out_pc=0, out_pc_plus4=4; following cycles deliver pc 4 then 8 back-to-back.
- out_ready=0 for 5 cycles from reset -> count saturates at 2 after 2 fetches and imem_addr holds 0x8. Raising out_ready delivers pc 0,4,8 in order with no loss or duplication.
- Queue FULL, redirect_valid=1 with redirect_pc=0x40 -> next cycle: out_valid=0, imem_addr=0x40; cycle after: out_valid=1, out_pc=0x40, out_instr=ROM[16].
- redirect_pc=0x42 -> misalign_err=1 and fetch from 0x40. misalign_err stays 1 through later redirects and clears only on reset.
- reset asserted mid-stream between clock edges -> out_valid=0 and imem_addr=RESET_PC immediately; after deassertion, fetch restarts at RESET_PC.
- Redirect to 0xFFFF_FFFC, out_ready=1 -> next fetched PCs 0xFFFF_FFFC then 0x0000_0000; out_pc_plus4 for 0xFFFF_FFFC = 0x0.
